// File: rtl/lcd_dma_axi_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_dma_pkg                                                                |
// | Shared AXI constants, FSM state type and burst default for the LCD DMA.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package lcd_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam int         LCD_DMA_BURST_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } lcd_dma_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_dma_axi_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_dma_axi_reader_if                                                      |
// | AXI4 read-address and read-data channels (32-bit data) for the DMA reader.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface lcd_dma_axi_reader_if;

  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );

endinterface
`default_nettype wire

// File: rtl/lcd_dma_axi_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lcd_dma_axi_reader                                                         |
// | Turns a DMA_START request into one AXI4 INCR read burst and returns each  |
// | beat as a one-cycle DMA_RD_DATA_VALID strobe.                              |
// | Optional error counter: define LCD_DMA_ERR_CNT_EN.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module lcd_dma_axi_reader
  import lcd_dma_pkg::*;
#(
  parameter int BURST_LEN  = LCD_DMA_BURST_LEN,
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] DMA_RD_ADDR,
  input  logic                  DMA_START,
  output logic                  DMA_READY,
  output logic [31:0]           DMA_RD_DATA,
  output logic                  DMA_RD_DATA_VALID,
`ifdef LCD_DMA_ERR_CNT_EN
  output logic [15:0]           DMA_ERR_COUNT,
  output logic [0:0]            DMA_ERR_STICKY,
`endif
  lcd_dma_axi_reader_if.master  M_AXI
);

  localparam int             CNT_W     = 5;
  localparam logic [CNT_W-1:0] FWD_LIM   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] EARLY_LIM = CNT_W'(BURST_LEN - 1);

  lcd_dma_state_t   state_q, state_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             beat_hs;
  logic [31:0]      start_byte_addr;
  logic [ADDR_WIDTH+1:0] byte_addr_full;

  assign byte_addr_full = {DMA_RD_ADDR, 2'b00};

  generate
    if (ADDR_WIDTH + 2 >= 32) begin : g_addr_trunc
      assign start_byte_addr = byte_addr_full[31:0];
    end else begin : g_addr_ext
      assign start_byte_addr = {{(30 - ADDR_WIDTH){1'b0}}, byte_addr_full};
    end
  endgenerate

  assign beat_hs = (state_q == DATA) && M_AXI.RVALID;

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    beat_cnt_d = beat_cnt_q;
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (DMA_START) begin
          state_d    = ADDR;
          araddr_d   = start_byte_addr;
          beat_cnt_d = '0;
        end
      end
      ADDR: begin
        if (M_AXI.ARREADY) state_d = DATA;
      end
      DATA: begin
        if (M_AXI.RVALID) begin
          // Beats past BURST_LEN are still accepted so the interconnect drains.
          if (beat_cnt_q < FWD_LIM) begin
            rd_valid_d = 1'b1;
            rd_data_d  = M_AXI.RDATA;
          end
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + 1'b1;
          if (M_AXI.RLAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      araddr_q   <= '0;
      beat_cnt_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      beat_cnt_q <= beat_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign DMA_READY         = (state_q == IDLE);
  assign DMA_RD_DATA       = rd_data_q;
  assign DMA_RD_DATA_VALID = rd_valid_q;

  assign M_AXI.ARADDR  = araddr_q;
  assign M_AXI.ARLEN   = 8'(BURST_LEN - 1);
  assign M_AXI.ARSIZE  = AXI_SIZE_4B;
  assign M_AXI.ARBURST = AXI_BURST_INCR;
  assign M_AXI.ARVALID = (state_q == ADDR);
  assign M_AXI.RREADY  = (state_q == DATA);

`ifdef LCD_DMA_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_sticky_q, err_sticky_d;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  always_comb begin
    err_inc      = 2'd0;
    if (beat_hs && (M_AXI.RRESP != AXI_RESP_OKAY)) err_inc = err_inc + 2'd1;
    // An RLAST arriving before BURST_LEN beats counts as one short-burst error.
    if (beat_hs && M_AXI.RLAST && (beat_cnt_q < EARLY_LIM)) err_inc = err_inc + 2'd1;
    err_sum      = {1'b0, err_cnt_q} + 17'(err_inc);
    err_cnt_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    err_sticky_d = err_sticky_q | (err_inc != 2'd0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign DMA_ERR_COUNT  = err_cnt_q;
  assign DMA_ERR_STICKY = err_sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_dma_axi_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lcd_dma_axi_reader                                                      |
// | Directed/randomised bursts against a queue-based model of the DMA reader. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_lcd_dma_axi_reader;
  import lcd_dma_pkg::*;

  localparam int BL = 8;
  localparam int AW = 30;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [AW-1:0] DMA_RD_ADDR = '0;
  logic          DMA_START = 1'b0;
  logic          DMA_READY;
  logic [31:0]   DMA_RD_DATA;
  logic          DMA_RD_DATA_VALID;
`ifdef LCD_DMA_ERR_CNT_EN
  logic [15:0]   DMA_ERR_COUNT;
  logic [0:0]    DMA_ERR_STICKY;
`endif

  lcd_dma_axi_reader_if axi ();

  lcd_dma_axi_reader #(.BURST_LEN(BL), .ADDR_WIDTH(AW)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .DMA_RD_ADDR       (DMA_RD_ADDR),
    .DMA_START         (DMA_START),
    .DMA_READY         (DMA_READY),
    .DMA_RD_DATA       (DMA_RD_DATA),
    .DMA_RD_DATA_VALID (DMA_RD_DATA_VALID),
`ifdef LCD_DMA_ERR_CNT_EN
    .DMA_ERR_COUNT     (DMA_ERR_COUNT),
    .DMA_ERR_STICKY    (DMA_ERR_STICKY),
`endif
    .M_AXI             (axi)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          c;
    logic [31:0] d;
  } pulse_t;

  int     n_assert = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     ar_seen = 0;
  int     ar_exp = 0;
  int     idle_data_bad = 0;
  int     err_exp = 0;
  pulse_t exp_q[$];
  pulse_t obs_q[$];

  // Observed strobes and AR handshakes, sampled mid-cycle.
  always @(negedge CLK) begin
    if (DMA_RD_DATA_VALID === 1'b1) obs_q.push_back('{c: cyc, d: DMA_RD_DATA});
    else if (DMA_RD_DATA !== 32'h0) idle_data_bad++;
    if (axi.ARVALID === 1'b1 && axi.ARREADY === 1'b1) ar_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic check_pulses(input string tag);
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_cycle"}, 64'(obs_q[i].c), 64'(exp_q[i].c));
      chk({tag, "_data"}, 64'(obs_q[i].d), 64'(exp_q[i].d));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic run_burst(input string tag, input logic [AW-1:0] addr, input int ar_wait,
                           input int nbeats, input int gap_mode, input bit start_during,
                           input int err_beats, input int abort_after, input logic [31:0] data_base);
    logic [31:0] exp_addr;
    logic [31:0] d;
    logic [1:0]  resp;
    int          i;
    int          slot;
    bit          gap;
    exp_addr = 32'(64'(addr) * 4);
    chk({tag, "_ready_before"}, 64'(DMA_READY), 64'd1);
    DMA_RD_ADDR = addr;
    DMA_START   = 1'b1;
    tick();
    DMA_START   = 1'b0;
    DMA_RD_ADDR = AW'($urandom);
    check_pulses({tag, "_prev"});
    ar_exp++;
    for (int w = 0; w <= ar_wait; w++) begin
      chk({tag, "_arvalid"}, 64'(axi.ARVALID), 64'd1);
      chk({tag, "_araddr"}, 64'(axi.ARADDR), 64'(exp_addr));
      chk({tag, "_ready_addr"}, 64'(DMA_READY), 64'd0);
      chk({tag, "_rready_addr"}, 64'(axi.RREADY), 64'd0);
      if (w == 0) begin
        chk({tag, "_arlen"}, 64'(axi.ARLEN), 64'(BL - 1));
        chk({tag, "_arsize"}, 64'(axi.ARSIZE), 64'd2);
        chk({tag, "_arburst"}, 64'(axi.ARBURST), 64'd1);
      end
      axi.ARREADY = (w == ar_wait);
      tick();
    end
    axi.ARREADY = 1'b0;
    i = 0;
    slot = 0;
    while (i < nbeats && !(abort_after >= 0 && i == abort_after)) begin
      chk({tag, "_arvalid_data"}, 64'(axi.ARVALID), 64'd0);
      chk({tag, "_rready_data"}, 64'(axi.RREADY), 64'd1);
      chk({tag, "_ready_data"}, 64'(DMA_READY), 64'd0);
      gap = (gap_mode == 1 && (slot % 2) == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
      if (gap) begin
        axi.RVALID = 1'b0;
        axi.RLAST  = 1'($urandom);
        axi.RDATA  = $urandom;
        DMA_START  = start_during;
        tick();
        slot++;
        continue;
      end
      d    = (data_base != 0) ? data_base + 32'(i) : $urandom;
      resp = (i < err_beats) ? 2'b10 : 2'b00;
      axi.RVALID = 1'b1;
      axi.RDATA  = d;
      axi.RLAST  = (i == nbeats - 1);
      axi.RRESP  = resp;
      DMA_START  = start_during && (i != nbeats - 1);
      tick();
      if (i < BL) exp_q.push_back('{c: cyc, d: d});
      if (resp != 2'b00) err_exp++;
      i++;
      slot++;
    end
    axi.RVALID = 1'b0;
    axi.RLAST  = 1'b0;
    axi.RRESP  = 2'b00;
    DMA_START  = 1'b0;
    if (abort_after >= 0 && i == abort_after) begin
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      err_exp = 0;
      chk({tag, "_rst_ready"}, 64'(DMA_READY), 64'd1);
      chk({tag, "_rst_rready"}, 64'(axi.RREADY), 64'd0);
      chk({tag, "_rst_valid"}, 64'(DMA_RD_DATA_VALID), 64'd0);
      chk({tag, "_rst_arvalid"}, 64'(axi.ARVALID), 64'd0);
      check_pulses({tag, "_rst"});
    end else begin
      if (nbeats < BL) err_exp++;
      chk({tag, "_ready_end"}, 64'(DMA_READY), 64'd1);
      chk({tag, "_valid_end"}, 64'(DMA_RD_DATA_VALID), 64'(nbeats <= BL));
      chk({tag, "_rready_end"}, 64'(axi.RREADY), 64'd0);
    end
  endtask

  initial begin
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RDATA   = '0;
    axi.RRESP   = 2'b00;
    axi.RLAST   = 1'b0;
    RESET       = 1'b1;
    repeat (3) tick();
    chk("reset_ready", 64'(DMA_READY), 64'd1);
    chk("reset_data", 64'(DMA_RD_DATA), 64'd0);
    chk("reset_valid", 64'(DMA_RD_DATA_VALID), 64'd0);
    chk("reset_arvalid", 64'(axi.ARVALID), 64'd0);
    chk("reset_rready", 64'(axi.RREADY), 64'd0);
    chk("reset_araddr", 64'(axi.ARADDR), 64'd0);
`ifdef LCD_DMA_ERR_CNT_EN
    chk("reset_errcnt", 64'(DMA_ERR_COUNT), 64'd0);
    chk("reset_sticky", 64'(DMA_ERR_STICKY), 64'd0);
`endif
    RESET = 1'b0;
    tick();

    run_burst("basic", 30'h10000000, 0, 8, 0, 1'b0, 0, -1, 32'h1000);
    run_burst("ar_backpressure", AW'($urandom), 5, 8, 0, 1'b0, 0, -1, 32'h0);
    run_burst("gapped", AW'($urandom), 0, 8, 1, 1'b1, 0, -1, 32'h0);
    run_burst("b2b_first", AW'($urandom), 1, 8, 2, 1'b0, 0, -1, 32'h0);
    run_burst("b2b_second", AW'($urandom), 0, 8, 0, 1'b0, 0, -1, 32'h0);
    run_burst("reset_mid", AW'($urandom), 0, 8, 0, 1'b0, 0, 3, 32'h0);
    run_burst("after_reset", AW'($urandom), 0, 8, 0, 1'b0, 0, -1, 32'h0);
    run_burst("resp_err", AW'($urandom), 0, 8, 0, 1'b0, 2, -1, 32'h0);
    run_burst("short", AW'($urandom), 0, 5, 0, 1'b0, 0, -1, 32'h0);
`ifdef LCD_DMA_ERR_CNT_EN
    chk("err_count", 64'(DMA_ERR_COUNT), 64'(err_exp));
    chk("err_sticky", 64'(DMA_ERR_STICKY), 64'd1);
`endif
    run_burst("extra_beats", AW'($urandom), 0, 10, 2, 1'b0, 0, -1, 32'h0);
    for (int k = 0; k < 6; k++) begin
      run_burst("random", AW'($urandom), $urandom_range(0, 3), $urandom_range(1, 11), 2,
                1'($urandom_range(0, 1)), $urandom_range(0, 2), -1, 32'h0);
    end
    tick();
    check_pulses("final");
    chk("ar_count", 64'(ar_seen), 64'(ar_exp));
    chk("idle_data_zero", 64'(idle_data_bad), 64'd0);
`ifdef LCD_DMA_ERR_CNT_EN
    chk("err_count_final", 64'(DMA_ERR_COUNT), 64'(err_exp));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
